// File: rtl/voting_pkg.sv
// Shared types and width helpers for the ballot controller and its timeout counter.
// Pure declarations; no logic or storage lives here.
package voting_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ACK = 3'd1,
        WAIT_REL = 3'd2,
        TALLY    = 3'd3,
        DONE     = 3'd4
    } state_e;

    localparam int N_VOTERS_DEF = 5;
    localparam int MAJ          = N_VOTERS_DEF / 2 + 1;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int width_for(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic int majority(input int n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/voting_ballot_ctrl_if.sv
// Ballot bus between the controller (master) and the voter stations / result logic (slave).
// Carries the 4-phase req/ack pairs, the vote lines and the result outputs.
interface voting_ballot_ctrl_if #(
    parameter int N_VOTERS = 5,
    parameter int CNT_W    = 4
);
    logic                start;
    logic [N_VOTERS-1:0] vote_req;
    logic [N_VOTERS-1:0] vote_ack;
    logic [N_VOTERS-1:0] vote_val;
    logic                busy;
    logic                done;
    logic                pass;
    logic [CNT_W-1:0]    yes_cnt;
    logic [N_VOTERS-1:0] resp_mask;
    logic                tmo_err;

    modport master (
        input  start, vote_ack, vote_val,
        output vote_req, busy, done, pass, yes_cnt, resp_mask, tmo_err
    );

    modport slave (
        output start, vote_ack, vote_val,
        input  vote_req, busy, done, pass, yes_cnt, resp_mask, tmo_err
    );
endinterface

// File: rtl/voting_tmo_timer.sv
// Clearable saturating wait counter; o_hit flags the last permitted cycle (TMO_CYC-1).
// Clear has priority over enable; the count parks at the limit instead of wrapping.
module voting_tmo_timer
    import voting_pkg::*;
#(
    parameter int TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);
    localparam int            TW    = width_for(TMO_CYC);
    localparam logic [TW-1:0] LIMIT = TW'(TMO_CYC - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_hit = (r_cnt == LIMIT);

endmodule

// File: rtl/voting_ballot_ctrl.sv
// Polls N voter stations in turn over 4-phase req/ack, tallies yes votes, pulses done with a strict-majority result.
// Two cycles per zero-wait station plus TALLY and DONE; slow stations stall the poll up to TMO_CYC cycles per ack edge.
module voting_ballot_ctrl
    import voting_pkg::*;
#(
    parameter int N_VOTERS = N_VOTERS_DEF,
    parameter int TMO_CYC  = 255,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    voting_ballot_ctrl_if.master vb
);
    localparam int                  IDX_W    = width_for(N_VOTERS);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_VOTERS - 1);
    localparam logic [CNT_W-1:0]    MAJ_CNT  = CNT_W'(majority(N_VOTERS));

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_WAIT_ACK = WAIT_ACK;
    localparam logic [2:0] S_WAIT_REL = WAIT_REL;
    localparam logic [2:0] S_TALLY    = TALLY;
    localparam logic [2:0] S_DONE     = DONE;

    logic [2:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_yes;
    logic [N_VOTERS-1:0] r_mask;
    logic                r_tmo;
    logic                r_pass;
    logic                r_done;

    logic                w_ack_sel;
    logic                w_val_sel;
    logic                w_tmr_hit;
    logic                w_wait;
    logic                w_leave;
    logic                w_tmr_clr;
    logic                w_last;
    logic [N_VOTERS-1:0] w_req;

    assign w_ack_sel = vb.vote_ack[r_idx];
    assign w_val_sel = vb.vote_val[r_idx];
    assign w_last    = (r_idx == LAST_IDX);
    assign w_wait    = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_REL);

    // Any exit from a wait phase restarts the timer so each ack edge gets a full budget.
    assign w_leave   = ((r_state == S_WAIT_ACK) && (w_ack_sel || w_tmr_hit)) ||
                       ((r_state == S_WAIT_REL) && (!w_ack_sel || w_tmr_hit));
    assign w_tmr_clr = !w_wait || w_leave;

    voting_tmo_timer #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_tmr_clr),
        .i_en  (w_wait),
        .o_hit (w_tmr_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_yes   <= '0;
            r_mask  <= '0;
            r_tmo   <= 1'b0;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (vb.start) begin
                        r_yes   <= '0;
                        r_mask  <= '0;
                        r_tmo   <= 1'b0;
                        r_pass  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_ack_sel) begin
                        r_yes         <= r_yes + CNT_W'(w_val_sel);
                        r_mask[r_idx] <= 1'b1;
                        r_state       <= S_WAIT_REL;
                    end else if (w_tmr_hit) begin
                        // Silent station counts as a no vote; move straight on.
                        r_tmo <= 1'b1;
                        if (w_last) begin
                            r_state <= S_TALLY;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_WAIT_ACK;
                        end
                    end
                end
                S_WAIT_REL: begin
                    if (!w_ack_sel || w_tmr_hit) begin
                        if (w_ack_sel) r_tmo <= 1'b1;
                        if (w_last) begin
                            r_state <= S_TALLY;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_WAIT_ACK;
                        end
                    end
                end
                S_TALLY: begin
                    r_pass  <= (r_yes >= MAJ_CNT);
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Request is decoded from registered state, so a reset edge drops it immediately.
    always_comb begin
        w_req = '0;
        if (r_state == S_WAIT_ACK) w_req[r_idx] = 1'b1;
    end

    assign vb.vote_req  = w_req;
    assign vb.busy      = w_wait || (r_state == S_TALLY);
    assign vb.done      = r_done;
    assign vb.pass      = r_pass;
    assign vb.yes_cnt   = r_yes;
    assign vb.resp_mask = r_mask;
    assign vb.tmo_err   = r_tmo;

endmodule
